note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
- Plays a programmed tune by driving the 3-bit note select of the tone divider (do..DO, 000..111) and a tone enable that gates its output to the audio path.
- Holds a small note table written by the host. Each entry gives a note select, a rest flag and a duration in beats.
- Steps through the table with a beat prescaler and an optional silent gap between notes. Supports single play, loop and stop.

Parameters:
- BEAT_DIV, 12500000, inclk cycles per beat (50 MHz gives 4 beats/s); must be >= 1.
- GAP_TICKS, 1250000, silent inclk cycles after each note; 0 means no gap state.
- DEPTH, 16, note table entries; power of two, 2..16.

Ports:
- inclk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  table write strobe.
- wr_addr  in  4  table write address; only the low log2(DEPTH) bits are used.
- wr_data  in  8  entry: [7] rest, [6:4] sel, [3:0] duration in beats.
- seq_len  in  5  number of entries to play; valid range 1..DEPTH; sampled on start.
- start  in  1  begin playback; level sampled each cycle.
- stop  in  1  abort playback.
- loop  in  1  level; when 1, wrap to entry 0 after the last entry.
- sel  out  3  note select to the divider.
- tone_on  out  1  1 = audible note.
- busy  out  1  1 while not IDLE.
- step  out  4  index of the current entry.
- done  out  1  one-cycle pulse when a non-looping playback completes.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; sel=0, tone_on=0, busy=0, step=0, done=0.
  - Beat counter, beat-left counter and gap counter are all cleared.
  - Table contents are not reset.
- Table writes:
  - Synchronous; wr_data is stored at wr_addr on any cycle with wr_en=1, in any state.
  - An entry written during playback takes effect the next time that entry is fetched.
- States: IDLE, FETCH, PLAY, GAP, ADVANCE. All outputs are registered. busy = (state != IDLE).
- IDLE:
  - Requires start=1 and stop=0.
  - If 1 <= seq_len <= DEPTH: latch seq_len into len, set step=0, go to FETCH.
  - Otherwise start is ignored and the block stays in IDLE.
- FETCH (1 cycle):
  - Read entry[step]; register sel, rest and dur. A duration of 0 is treated as 1.
  - Clear the beat counter, load beat_left=dur, go to PLAY.
- PLAY (exactly dur*BEAT_DIV cycles):
  - tone_on = ~rest.
  - The beat counter runs 0..BEAT_DIV-1 and wraps; beat_left decrements at each wrap.
  - On the wrap with beat_left==1: go to GAP if GAP_TICKS>0, else to ADVANCE.
- GAP (GAP_TICKS cycles): tone_on=0; sel holds.
- ADVANCE (1 cycle), with tone_on=0:
  - If step==len-1 and loop=1: step=0, go to FETCH.
  - If step==len-1 and loop=0: done=1 for this cycle only, go to IDLE.
  - Otherwise: step=step+1, go to FETCH.
- Per-note period is 2 + dur*BEAT_DIV + GAP_TICKS cycles.
- stop:
  - When stop=1 in any non-IDLE state, the next state is IDLE with tone_on=0.
  - step and sel keep their last values; done is not pulsed.
  - stop takes priority over start in the same cycle.
- start while busy is ignored.
- A loop change mid-playback is honoured at the next ADVANCE.
- In IDLE, sel holds its last value and tone_on=0.
- Reset asserted mid-operation returns the block to IDLE immediately, with outputs at their reset values.

Test Plan:
All scenarios use BEAT_DIV=4, GAP_TICKS=2, DEPTH=8, with cycle 0 being the edge that samples start.
1. Reset: hold reset=0 for 3 cycles -> sel=0, tone_on=0, busy=0, step=0, done=0; start with reset low has no effect.
2. Single play:
   - Stimulus: write entry0=0x42 (so, 2 beats), entry1=0x81 (rest, 1 beat), entry2=0x73 (DO, 3 beats); seq_len=3, loop=0, pulse start.
   - Required: sel=100 with tone_on=1 for exactly 8 cycles.
   - Then 2 gap cycles and 1 advance cycle with tone_on=0, then tone_on=0 for 4 cycles during the rest.
   - Then sel=111 with tone_on=1 for 12 cycles.
   - done pulses once, 36 cycles after start; busy falls in the same cycle.
3. Loop: same table with loop=1 -> after entry2, step returns to 0 and sel=100 re-asserts; done never pulses. Clearing loop mid-tune -> done pulses at the end of that pass.
4. Stop: assert stop at cycle 5 of the first note -> next cycle tone_on=0, busy=0, step=0, no done. start and stop asserted together in IDLE -> stays IDLE.
5. Edge inputs:
   - entry with duration 0 -> plays 4 cycles.
   - seq_len=0 or seq_len=9 with start -> busy stays 0.
   - Write to entry1 while entry0 is playing -> the new value is heard.
6. Async reset: drop reset mid-PLAY, asynchronous to inclk -> outputs return to reset values before the next edge; release, then start -> playback begins from entry 0.

Source files
------------

// File: rtl/note_sequencer.sv
// Note-table tune player: steps host-written entries through PLAY/GAP timing
// and drives the tone divider's note select and audio enable.
module note_sequencer #(
  parameter int unsigned BEAT_DIV  = 12500000,
  parameter int unsigned GAP_TICKS = 1250000,
  parameter int unsigned DEPTH     = 16
) (
  input  logic       inclk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [4:0] seq_len,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  output logic [2:0] sel,
  output logic       tone_on,
  output logic       busy,
  output logic [3:0] step,
  output logic       done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned BW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam int unsigned GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_TICKS == 0) ? 0 : GAP_TICKS - 1);
  localparam logic [5:0]    DEPTH_L   = 6'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PLAY,
    S_GAP,
    S_ADVANCE
  } state_t;

  state_t state_q, state_d;

  logic [7:0]    mem [DEPTH];
  logic [7:0]    entry;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [3:0]    beat_left_q, beat_left_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [4:0]    len_q, len_d;
  logic          rest_q, rest_d;
  logic [2:0]    sel_q, sel_d;
  logic          tone_q, tone_d;
  logic          busy_q;
  logic [3:0]    step_q, step_d;
  logic          done_q, done_d;
  logic          seq_len_ok;
  logic          last_step;
  logic          unused_bits;

  // Table is deliberately not reset; the host owns its contents.
  always_ff @(posedge inclk) begin
    if (wr_en) begin
      mem[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  assign entry       = mem[step_q[AW-1:0]];
  assign seq_len_ok  = (seq_len != 5'd0) && ({1'b0, seq_len} <= DEPTH_L);
  assign last_step   = (({1'b0, step_q} + 5'd1) == len_q);
  assign unused_bits = ^{wr_addr, step_q};

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    beat_left_d = beat_left_q;
    gap_cnt_d   = gap_cnt_q;
    len_d       = len_q;
    rest_d      = rest_q;
    sel_d       = sel_q;
    step_d      = step_q;
    tone_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop && seq_len_ok) begin
          len_d   = seq_len;
          step_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        sel_d       = entry[6:4];
        rest_d      = entry[7];
        beat_left_d = (entry[3:0] == 4'd0) ? 4'd1 : entry[3:0];
        beat_cnt_d  = '0;
        tone_d      = ~entry[7];
        state_d     = S_PLAY;
      end
      S_PLAY: begin
        tone_d = ~rest_q;
        if (beat_cnt_q == BEAT_LAST) begin
          beat_cnt_d  = '0;
          beat_left_d = beat_left_q - 4'd1;
          if (beat_left_q == 4'd1) begin
            tone_d = 1'b0;
            if (GAP_TICKS > 0) begin
              gap_cnt_d = '0;
              state_d   = S_GAP;
            end else begin
              state_d   = S_ADVANCE;
            end
          end
        end else begin
          beat_cnt_d = beat_cnt_q + BW'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_ADVANCE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      S_ADVANCE: begin
        if (last_step) begin
          if (loop) begin
            step_d  = '0;
            state_d = S_FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          step_d  = step_q + 4'd1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides whatever the state arm decided, freezing step/sel.
    if (stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      tone_d  = 1'b0;
      done_d  = 1'b0;
      step_d  = step_q;
      sel_d   = sel_q;
      rest_d  = rest_q;
    end
  end

  always_ff @(posedge inclk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      beat_cnt_q  <= '0;
      beat_left_q <= '0;
      gap_cnt_q   <= '0;
      len_q       <= '0;
      rest_q      <= 1'b0;
      sel_q       <= '0;
      tone_q      <= 1'b0;
      busy_q      <= 1'b0;
      step_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      beat_left_q <= beat_left_d;
      gap_cnt_q   <= gap_cnt_d;
      len_q       <= len_d;
      rest_q      <= rest_d;
      sel_q       <= sel_d;
      tone_q      <= tone_d;
      busy_q      <= (state_d != S_IDLE);
      step_q      <= step_d;
      done_q      <= done_d;
    end
  end

  assign sel     = sel_q;
  assign tone_on = tone_q;
  assign busy    = busy_q;
  assign step    = step_q;
  assign done    = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed scenarios plus random tunes checked
// cycle-by-cycle against a timeline built from the note table.
module tb_note_sequencer;

  localparam int BD = 4;
  localparam int GT = 2;
  localparam int DP = 8;

  logic       inclk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [4:0] seq_len = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop = 1'b0;
  logic [2:0] sel;
  logic       tone_on;
  logic       busy;
  logic [3:0] step;
  logic       done;

  note_sequencer #(.BEAT_DIV(BD), .GAP_TICKS(GT), .DEPTH(DP)) dut (
    .inclk(inclk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .seq_len(seq_len), .start(start), .stop(stop),
    .loop(loop), .sel(sel), .tone_on(tone_on), .busy(busy), .step(step),
    .done(done)
  );

  always #5 inclk = ~inclk;

  typedef struct packed {
    logic [2:0] sel;
    logic       tone;
    logic       busy;
    logic [3:0] step;
    logic       done;
  } obs_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] tbl [DP];
  logic [2:0] cur_sel;
  obs_t       q[$];
  int         pass1_len;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic obs_t cur_obs();
    return {sel, tone_on, busy, step, done};
  endfunction

  task automatic tick();
    @(posedge inclk);
    #1;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = 4'(a);
    wr_data = d;
    tick();
    wr_en   = 1'b0;
    tbl[a]  = d;
  endtask

  // Expected outputs after each edge: per note one fetch cycle, dur*BD play
  // cycles, GT gap cycles and one advance cycle; then done and idle.
  task automatic build(input int len, input int npass);
    int d;
    q.delete();
    pass1_len = 0;
    for (int p = 0; p < npass; p++) begin
      for (int n = 0; n < len; n++) begin
        d = (tbl[n][3:0] == 4'd0) ? 1 : int'(tbl[n][3:0]);
        q.push_back({cur_sel, 1'b0, 1'b1, 4'(n), 1'b0});
        cur_sel = tbl[n][6:4];
        for (int c = 0; c < d * BD; c++) q.push_back({cur_sel, ~tbl[n][7], 1'b1, 4'(n), 1'b0});
        for (int c = 0; c < GT + 1; c++) q.push_back({cur_sel, 1'b0, 1'b1, 4'(n), 1'b0});
      end
      if (p == 0) pass1_len = q.size();
    end
    q.push_back({cur_sel, 1'b0, 1'b0, 4'(len - 1), 1'b1});
    q.push_back({cur_sel, 1'b0, 1'b0, 4'(len - 1), 1'b0});
  endtask

  task automatic run(input string tag, input int len, input bit lp, input int npass,
                     input int wr_at, input int wa, input logic [7:0] wd);
    build(len, npass);
    seq_len = 5'(len);
    loop    = lp;
    start   = 1'b1;
    for (int k = 0; k < q.size(); k++) begin
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      chk($sformatf("%s[%0d]", tag, k), 32'(cur_obs()), 32'(q[k]));
      if (k == wr_at) begin
        wr_en   = 1'b1;
        wr_addr = 4'(wa);
        wr_data = wd;
      end
      if (npass > 1 && k == pass1_len) loop = 1'b0;
    end
    wr_en = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    cur_sel = '0;
    for (int i = 0; i < DP; i++) tbl[i] = '0;

    // Reset held with start asserted.
    start   = 1'b1;
    seq_len = 5'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("reset[%0d]", i), 32'(cur_obs()), 32'h0);
    end
    start = 1'b0;
    reset = 1'b1;
    tick();
    chk("post_reset_idle", 32'(cur_obs()), 32'h0);

    // Table writes clear the whole table first so every entry is defined.
    for (int i = 0; i < DP; i++) wr(i, 8'h00);
    wr(0, 8'h42);
    wr(1, 8'h81);
    wr(2, 8'h73);
    run("single", 3, 1'b0, 1, -1, 0, 8'h00);
    chk("single_done_at_36", 32'(q[36].done), 32'h1);

    run("loop", 3, 1'b1, 2, -1, 0, 8'h00);

    // Stop sampled on edge 5, during the first note.
    seq_len = 5'd3;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_obs", 32'(cur_obs()), 32'({3'b100, 1'b0, 1'b0, 4'd0, 1'b0}));
    tick();
    chk("stop_no_done", 32'(cur_obs()), 32'({3'b100, 1'b0, 1'b0, 4'd0, 1'b0}));
    cur_sel = 3'b100;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    chk("start_stop_idle0", 32'(busy), 32'h0);
    tick();
    chk("start_stop_idle1", 32'(busy), 32'h0);
    start = 1'b0;
    stop  = 1'b0;

    // Duration 0 plays as one beat.
    wr(0, 8'h50);
    run("dur0", 1, 1'b0, 1, -1, 0, 8'h00);

    // Out-of-range lengths are ignored.
    start   = 1'b1;
    seq_len = 5'd0;
    tick();
    tick();
    chk("len0_busy", 32'(busy), 32'h0);
    seq_len = 5'd9;
    tick();
    tick();
    chk("len9_busy", 32'(busy), 32'h0);
    start = 1'b0;
    tick();

    // Entry 1 rewritten while entry 0 plays.
    wr(0, 8'h42);
    wr(1, 8'h81);
    tbl[1] = 8'h35;
    run("live_write", 2, 1'b0, 1, 3, 1, 8'h35);

    // Random tunes, optionally looping once before loop is cleared.
    for (int r = 0; r < 6; r++) begin
      bit lp;
      int len;
      for (int i = 0; i < DP; i++) begin
        wr(i, {4'($urandom_range(0, 15)), 4'($urandom_range(0, 5))});
      end
      len = int'($urandom_range(1, DP));
      lp  = 1'($urandom_range(0, 1));
      run($sformatf("rand%0d", r), len, lp, lp ? 2 : 1, -1, 0, 8'h00);
    end

    // Asynchronous reset mid-PLAY.
    wr(0, 8'h42);
    wr(1, 8'h81);
    wr(2, 8'h73);
    seq_len = 5'd3;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    #2 reset = 1'b0;
    #1;
    chk("async_reset", 32'(cur_obs()), 32'h0);
    tick();
    chk("async_reset_held", 32'(cur_obs()), 32'h0);
    reset   = 1'b1;
    cur_sel = '0;
    tick();
    run("after_reset", 3, 1'b0, 1, -1, 0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
